// File: rtl/mem_arbiter.sv
// Shares a single-ported RAM between instruction fetch (i-side) and load/store (d-side).
// The d-side has priority, bounded by a streak guard; a per-access timeout aborts a hung RAM.
module mem_arbiter #(
    parameter int unsigned MAX_DSTREAK = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        derr,
    output logic        ierr,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);
    localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [2:0] {IDLE, IGNT, DGNT, IRESP, DRESP} state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     store_q, store_d;
    logic            ren_q, ren_d;
    logic            wen_q, wen_d;
    logic [31:0]     iload_q, iload_d;
    logic [31:0]     dload_q, dload_d;
    logic            ierr_q, ierr_d;
    logic            derr_q, derr_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic d_req, i_forced, done_ok, done_err;

    // Arbitration, grant capture and completion handling.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        store_d  = store_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        iload_d  = iload_q;
        dload_d  = dload_q;
        ierr_d   = 1'b0;
        derr_d   = 1'b0;
        streak_d = streak_q;
        tmo_d    = tmo_q;
        d_req    = dREN | dWEN;
        i_forced = iREN && (streak_q == SW'(MAX_DSTREAK));
        done_ok  = (ramstate == ACCESS);
        done_err = !done_ok && ((ramstate == ERROR) || (tmo_q == TW'(TIMEOUT - 1)));

        unique case (state_q)
            IDLE: begin
                if (!iREN) streak_d = '0;
                if (d_req && !i_forced) begin
                    state_d = DGNT;
                    addr_d  = daddr;
                    store_d = dstore;
                    wen_d   = dWEN;
                    ren_d   = !dWEN;
                    tmo_d   = '0;
                    if (iREN && (streak_q < SW'(MAX_DSTREAK))) streak_d = streak_q + SW'(1);
                end else if (iREN) begin
                    state_d  = IGNT;
                    addr_d   = iaddr;
                    ren_d    = 1'b1;
                    wen_d    = 1'b0;
                    tmo_d    = '0;
                    streak_d = '0;
                end
            end
            IGNT, DGNT: begin
                if (done_ok || done_err) begin
                    state_d = (state_q == IGNT) ? IRESP : DRESP;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    // Writes and failed accesses leave the load registers untouched.
                    if (done_ok && !wen_q) begin
                        if (state_q == IGNT) iload_d = ramload;
                        else                 dload_d = ramload;
                    end
                    if (done_err) begin
                        if (state_q == IGNT) ierr_d = 1'b1;
                        else                 derr_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            store_q  <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            iload_q  <= '0;
            dload_q  <= '0;
            ierr_q   <= 1'b0;
            derr_q   <= 1'b0;
            streak_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
            ierr_q   <= ierr_d;
            derr_q   <= derr_d;
            streak_q <= streak_d;
            tmo_q    <= tmo_d;
        end
    end

    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ierr     = ierr_q;
    assign derr     = derr_q;
    assign iwait    = iREN && (state_q != IRESP);
    assign dwait    = (dREN || dWEN) && (state_q != DRESP);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of both requesters and a behavioural RAM.
module tb_mem_arbiter;
    localparam int MAX_DSTREAK = 4;
    localparam int TIMEOUT     = 64;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
    localparam int NONE = 0, ISIDE = 1, DSIDE = 2;
    localparam int PH_IDLE = 0, PH_GRANT = 1, PH_RESP = 2;
    localparam int RM_OK = 0, RM_ERR = 1, RM_HANG = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, derr, ierr, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    mem_arbiter #(.MAX_DSTREAK(MAX_DSTREAK), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload), .derr(derr), .ierr(ierr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic wr; logic rd; logic [31:0] addr; logic [31:0] data; } dreq_t;
    typedef struct { int mode; int lat; } ram_t;

    logic [31:0] iq[$];
    dreq_t       dq[$];
    ram_t        rq[$];
    int          glog[$];
    logic [31:0] mem [logic [31:0]];

    int errors = 0;
    int checks = 0;

    // Transaction model state
    int          phase, owner, age, lat, mode, streak, obs_gnt;
    logic        m_wr, m_err;
    logic [31:0] m_addr, m_data;
    logic [31:0] exp_ramaddr, exp_ramstore, exp_iload, exp_dload;
    logic        i_act, d_act;
    bit          gaps;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0F0F);
    endfunction

    task automatic check_cycle();
        bit resp_i, resp_d;
        resp_i = (phase == PH_RESP) && (owner == ISIDE);
        resp_d = (phase == PH_RESP) && (owner == DSIDE);
        chk("ramREN",   32'(ramREN),   32'(phase == PH_GRANT && !m_wr));
        chk("ramWEN",   32'(ramWEN),   32'(phase == PH_GRANT && m_wr));
        chk("ramaddr",  ramaddr,       exp_ramaddr);
        chk("ramstore", ramstore,      exp_ramstore);
        chk("iwait",    32'(iwait),    32'(iREN && !resp_i));
        chk("dwait",    32'(dwait),    32'((dREN || dWEN) && !resp_d));
        chk("ierr",     32'(ierr),     32'(resp_i && m_err));
        chk("derr",     32'(derr),     32'(resp_d && m_err));
        chk("iload",    iload,         exp_iload);
        chk("dload",    dload,         exp_dload);
        if (ramREN || ramWEN) obs_gnt++;
        if (phase == PH_RESP && mode == RM_HANG) chk("timeout_len", 32'(obs_gnt), 32'(TIMEOUT));
    endtask

    task automatic grant(input int who, input logic wr, input logic [31:0] a, input logic [31:0] d);
        ram_t r;
        phase = PH_GRANT; owner = who; m_wr = wr; m_addr = a; m_data = d;
        age = 0; obs_gnt = 0; m_err = 1'b0;
        exp_ramaddr = a;
        if (who == DSIDE) exp_ramstore = d;
        if (rq.size() > 0) r = rq.pop_front();
        else begin
            r.mode = ($urandom_range(9) == 0) ? RM_ERR : RM_OK;
            r.lat  = int'($urandom_range(3));
        end
        mode = r.mode; lat = r.lat;
        glog.push_back(who);
    endtask

    // Requesters retire/issue, then the RAM answers and the model advances one cycle.
    task automatic drive();
        dreq_t r;
        if (phase == PH_RESP) begin
            if (owner == ISIDE) i_act = 1'b0;
            else                d_act = 1'b0;
        end
        if (!i_act && iq.size() > 0 && (!gaps || $urandom_range(2) != 0)) begin
            i_act = 1'b1;
            iaddr = iq.pop_front();
        end
        iREN = i_act;
        if (!i_act) iaddr = $urandom();
        if (!d_act && dq.size() > 0 && (!gaps || $urandom_range(2) != 0)) begin
            r = dq.pop_front();
            d_act = 1'b1; dREN = r.rd; dWEN = r.wr; daddr = r.addr; dstore = r.data;
        end
        if (!d_act) begin
            dREN = 1'b0; dWEN = 1'b0; daddr = $urandom(); dstore = $urandom();
        end

        ramstate = FREE;
        ramload  = $urandom();
        if (phase == PH_RESP) begin
            phase = PH_IDLE; owner = NONE;
        end else if (phase == PH_IDLE) begin
            if (!iREN) streak = 0;
            if ((dREN || dWEN) && !(iREN && streak == MAX_DSTREAK)) begin
                if (iREN && streak < MAX_DSTREAK) streak++;
                grant(DSIDE, dWEN, daddr, dstore);
            end else if (iREN) begin
                streak = 0;
                grant(ISIDE, 1'b0, iaddr, 32'h0);
            end
        end else begin
            if (mode == RM_HANG || age < lat) begin
                ramstate = ($urandom_range(1) != 0) ? BUSY : FREE;
                if (age == TIMEOUT - 1) begin phase = PH_RESP; m_err = 1'b1; end
                else age++;
            end else if (mode == RM_ERR) begin
                ramstate = ERROR; phase = PH_RESP; m_err = 1'b1;
            end else begin
                ramstate = ACCESS; phase = PH_RESP; m_err = 1'b0;
                if (m_wr) mem[m_addr] = m_data;
                else begin
                    ramload = memrd(m_addr);
                    if (owner == ISIDE) exp_iload = ramload;
                    else                exp_dload = ramload;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        check_cycle();
        drive();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || i_act || d_act || phase != PH_IDLE) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        assert (n < budget) else begin
            errors++;
            $error("FAIL drain_timeout: cycles=%0d limit=%0d", n, budget);
        end
    endtask

    task automatic model_reset();
        phase = PH_IDLE; owner = NONE; streak = 0; obs_gnt = 0; age = 0;
        mode = RM_OK; m_err = 1'b0; m_wr = 1'b0;
        exp_ramaddr = '0; exp_ramstore = '0; exp_iload = '0; exp_dload = '0;
        ramstate = FREE;
    endtask

    initial begin
        int exp3[7];
        nRST = 1'b0;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        i_act = 1'b0; d_act = 1'b0; gaps = 1'b0;
        model_reset();

        // Reset values
        repeat (3) begin @(negedge CLK); check_cycle(); end
        nRST = 1'b1;
        drive();

        // Single fetch, RAM answers after two BUSY cycles
        mem[32'h40] = 32'h00A0_0093;
        rq.push_back('{mode: RM_OK, lat: 2});
        iq.push_back(32'h40);
        run_until_idle(50);
        chk("t1_iload", iload, 32'h00A0_0093);

        // Simultaneous requests: d first, then i
        glog.delete();
        dq.push_back('{wr: 1'b0, rd: 1'b1, addr: 32'h100, data: 32'h0});
        iq.push_back(32'h44);
        run_until_idle(60);
        chk("t2_ngrants", 32'(glog.size()), 32'd2);
        chk("t2_first",  32'(glog[0]), 32'(DSIDE));
        chk("t2_second", 32'(glog[1]), 32'(ISIDE));

        // Streak guard: four d-grants, then the pending fetch is forced through
        glog.delete();
        for (int k = 0; k < 6; k++)
            dq.push_back('{wr: 1'b1, rd: 1'b0, addr: 32'h300 + 32'(4 * k), data: $urandom()});
        iq.push_back(32'h48);
        run_until_idle(120);
        exp3 = '{DSIDE, DSIDE, DSIDE, DSIDE, ISIDE, DSIDE, DSIDE};
        chk("t3_ngrants", 32'(glog.size()), 32'd7);
        for (int k = 0; k < 7 && k < glog.size(); k++) chk("t3_order", 32'(glog[k]), 32'(exp3[k]));

        // Write answered with ERROR
        rq.push_back('{mode: RM_ERR, lat: 1});
        dq.push_back('{wr: 1'b1, rd: 1'b0, addr: 32'h200, data: 32'hDEAD_BEEF});
        run_until_idle(60);

        // Fetch with the RAM stuck BUSY
        rq.push_back('{mode: RM_HANG, lat: 0});
        iq.push_back(32'h80);
        run_until_idle(200);

        // Reset during a d-grant; the held request is re-arbitrated afterwards
        mem[32'h240] = 32'h1234_5678;
        rq.push_back('{mode: RM_HANG, lat: 0});
        rq.push_back('{mode: RM_OK, lat: 1});
        dq.push_back('{wr: 1'b0, rd: 1'b1, addr: 32'h240, data: 32'h0});
        for (int n = 0; n < 10 && !(phase == PH_GRANT && owner == DSIDE); n++) tick();
        tick();
        tick();
        #2 nRST = 1'b0;
        #1;
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        model_reset();
        repeat (2) begin @(negedge CLK); check_cycle(); end
        nRST = 1'b1;
        drive();
        run_until_idle(60);
        chk("t6_dload", dload, 32'h1234_5678);

        // Randomized mixed traffic over a small address pool
        gaps = 1'b1;
        for (int k = 0; k < 60; k++) begin
            logic w;
            iq.push_back(32'h1000 + 32'(4 * $urandom_range(7)));
            w = ($urandom_range(1) != 0);
            dq.push_back('{wr: w, rd: (!w || $urandom_range(3) == 0),
                           addr: 32'h1000 + 32'(4 * $urandom_range(7)), data: $urandom()});
        end
        run_until_idle(4000);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
